// File: rtl/sprite_queue_if.sv
// rtl/sprite_queue_if.sv - sprite draw-command queue bus (producer/consumer/status; stats with SPRITE_QUEUE_STATS_EN)
interface sprite_queue_if #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             clear;
    logic             enqueue;
    logic [7:0]       enq_sprite_id;
    logic [15:0]      enq_sprite_x;
    logic [15:0]      enq_sprite_y;
    logic [7:0]       enq_sprite_scale;
    logic             is_full;
    logic             dequeue;
    logic             is_empty;
    logic [7:0]       sprite_id;
    logic [15:0]      sprite_x;
    logic [15:0]      sprite_y;
    logic [7:0]       sprite_scale;
    logic [CNT_W-1:0] count;
    logic             overflow;
`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]      overflow_count;
    logic [CNT_W-1:0] high_water;
`endif

    modport master (
        output clear, enqueue, enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale, dequeue,
        input  is_full, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
`ifdef SPRITE_QUEUE_STATS_EN
        , input overflow_count, high_water
`endif
    );

    modport slave (
        input  clear, enqueue, enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale, dequeue,
        output is_full, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count, overflow
`ifdef SPRITE_QUEUE_STATS_EN
        , output overflow_count, high_water
`endif
    );
endinterface

// File: rtl/sprite_queue.sv
// rtl/sprite_queue.sv - first-word-fall-through sprite draw-command FIFO (optional stats: SPRITE_QUEUE_STATS_EN)
module sprite_queue #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset,
    sprite_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [47:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf;
    logic             full;
    logic             empty;
    logic             enq_ok;
    logic             deq_ok;
    logic             drop;

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign enq_ok = bus.enqueue && (!full || bus.dequeue);
    assign deq_ok = bus.dequeue && !empty;
    assign drop   = bus.enqueue && full && !bus.dequeue;

    always_comb begin
        cnt_next = cnt;
        if (enq_ok && !deq_ok) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!enq_ok && deq_ok) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt_next;
            if (drop) ovf <= 1'b1;
        end
    end

    // Storage is not reset; entries past the pointers are never exposed.
    always_ff @(posedge clock) begin
        if (enq_ok && !bus.clear) begin
            mem[wr_ptr] <= {bus.enq_sprite_id, bus.enq_sprite_x, bus.enq_sprite_y, bus.enq_sprite_scale};
        end
    end

    assign {bus.sprite_id, bus.sprite_x, bus.sprite_y, bus.sprite_scale} = empty ? 48'd0 : mem[rd_ptr];
    assign bus.is_full  = full;
    assign bus.is_empty = empty;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;

`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]      ovf_cnt;
    logic [CNT_W-1:0] hw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_cnt <= '0;
            hw      <= '0;
        end else if (bus.clear) begin
            ovf_cnt <= '0;
            hw      <= '0;
        end else begin
            if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            if (cnt_next > hw) hw <= cnt_next;
        end
    end

    assign bus.overflow_count = ovf_cnt;
    assign bus.high_water     = hw;
`endif
endmodule
